sipo_frame_rx: RTL and testbench

//  Receive end of the single-bit serial link driven by the SISO shift chain. Frames the

---
 rtl/sipo_pkg.sv | 16 +
 rtl/sipo_fifo2.sv | 62 ++++++
 rtl/sipo_frame_rx.sv | 117 +++++++++++
 tb/tb_sipo_frame_rx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared FSM encoding and line-level constants for the serial frame receiver
package sipo_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      PAR  = 2'd2,
      STOP = 2'd3
   } state_t;

   localparam logic START_BIT   = 1'b1;
   localparam logic STOP_BIT    = 1'b0;
   localparam logic IDLE_LEVEL  = 1'b0;
   localparam int   QUEUE_DEPTH = 2;

endpackage

// File: rtl/sipo_fifo2.sv
// rtl/sipo_fifo2.sv - two-entry word queue with registered head output
module sipo_fifo2
   import sipo_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   output logic         full,
   input  logic         pop,
   output logic         empty,
   output logic [W-1:0] dout
);

   logic [W-1:0] mem0;
   logic [W-1:0] mem1;
   logic [1:0]   count;

   assign dout  = mem0;
   assign empty = (count == 2'd0);
   assign full  = (count == 2'(QUEUE_DEPTH));

   // mem0 is always the head; a pop shifts mem1 forward, a push fills the first free slot
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem0  <= '0;
         mem1  <= '0;
         count <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (!full) begin
                  if (empty) mem0 <= din;
                  else       mem1 <= din;
                  count <= count + 2'd1;
               end
            end
            2'b01: begin
               if (!empty) begin
                  mem0  <= mem1;
                  count <= count - 2'd1;
               end
            end
            2'b11: begin
               if (count == 2'd1) begin
                  mem0 <= din;
               end else if (full) begin
                  mem0 <= mem1;
                  mem1 <= din;
               end else begin
                  mem0  <= din;
                  count <= 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/sipo_frame_rx.sv
// rtl/sipo_frame_rx.sv - serial frame receiver and deserialiser; optional parity via SIPO_FRAME_RX_PARITY_EN
module sipo_frame_rx
   import sipo_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   output logic [WIDTH-1:0] dout,
   output logic             dout_vld,
   input  logic             dout_rdy,
   output logic             frame_err,
   output logic             ovf,
   input  logic             ovf_clr
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state;
   state_t           state_n;
   logic [CNT_W-1:0] bit_cnt;
   logic [WIDTH-1:0] shreg;
   logic             bit_last;
   logic             push;
   logic             bad;
   logic             pop;
   logic             full;
   logic             empty;
   logic             par_err;

   assign bit_last = (bit_cnt == CNT_LAST);
   assign dout_vld = !empty;
   assign pop      = dout_vld && dout_rdy;

   // frame state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   // next state; in STOP a good frame pushes the word, anything else is a framing error
   always_comb begin
      state_n = state;
      push    = 1'b0;
      bad     = 1'b0;
      case (state)
         IDLE: if (sin == START_BIT) state_n = DATA;
         DATA: begin
            if (bit_last) begin
`ifdef SIPO_FRAME_RX_PARITY_EN
               state_n = PAR;
`else
               state_n = STOP;
`endif
            end
         end
         PAR:  state_n = STOP;
         STOP: begin
            state_n = IDLE;
            if (sin == STOP_BIT && !par_err) push = 1'b1;
            else                             bad  = 1'b1;
         end
         default: state_n = IDLE;
      endcase
   end

   // LSB-first deserialisation; counter restarts on every start bit and never wraps past WIDTH-1
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bit_cnt <= '0;
         shreg   <= '0;
      end else if (state == IDLE) begin
         bit_cnt <= '0;
      end else if (state == DATA) begin
         shreg[bit_cnt] <= sin;
         bit_cnt        <= bit_last ? '0 : bit_cnt + 1'b1;
      end
   end

`ifdef SIPO_FRAME_RX_PARITY_EN
   // even parity: the parity bit must equal the XOR of the data bits
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                par_err <= 1'b0;
      else if (state == PAR)   par_err <= (sin != ^shreg);
   end
`else
   assign par_err = 1'b0;
`endif

   // error pulse and sticky overflow; a new drop beats a simultaneous clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_err <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         frame_err <= bad;
         if (push && full && !pop) ovf <= 1'b1;
         else if (ovf_clr)         ovf <= 1'b0;
      end
   end

   sipo_fifo2 #(
      .W (WIDTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (shreg),
      .full  (full),
      .pop   (pop),
      .empty (empty),
      .dout  (dout)
   );

endmodule

// File: tb/tb_sipo_frame_rx.sv
// tb/tb_sipo_frame_rx.sv - directed and scoreboard checks for sipo_frame_rx at WIDTH=4
module tb_sipo_frame_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sin = 1'b0;
   logic [3:0] dout;
   logic       dout_vld;
   logic       dout_rdy = 1'b0;
   logic       frame_err;
   logic       ovf;
   logic       ovf_clr = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [3:0] mq[$];
   logic       movf = 1'b0;

   typedef struct packed {
      logic       sin;
      logic       rdy;
      logic       clr;
      logic       vld;
      logic [3:0] dout;
      logic       err;
      logic       ovf;
   } vec_t;

   vec_t tbl[$];

   sipo_frame_rx #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .sin       (sin),
      .dout      (dout),
      .dout_vld  (dout_vld),
      .dout_rdy  (dout_rdy),
      .frame_err (frame_err),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic s, r, c, v, input logic [3:0] d, input logic e, o);
      tbl.push_back({s, r, c, v, d, e, o});
   endtask

   task automatic tick(input logic s, r, c, pe, ee, input logic [3:0] w);
      logic drop;
      sin      = s;
      dout_rdy = r;
      ovf_clr  = c;
      @(posedge clk);
      if (mq.size() > 0 && r) void'(mq.pop_front());
      drop = 1'b0;
      if (pe) begin
         if (mq.size() < 2) mq.push_back(w);
         else               drop = 1'b1;
      end
      if (drop)   movf = 1'b1;
      else if (c) movf = 1'b0;
      #1;
      chk("sb_vld", 32'(dout_vld), 32'(mq.size() > 0));
      if (mq.size() > 0) chk("sb_dout", 32'(dout), 32'(mq[0]));
      chk("sb_err", 32'(frame_err), 32'(ee));
      chk("sb_ovf", 32'(ovf), 32'(movf));
   endtask

   task automatic frame(input logic [3:0] d, input logic [6:0] rb, input logic c, input logic good);
      tick(1'b1, rb[0], c, 1'b0, 1'b0, d);
      for (int i = 0; i < 4; i++) tick(d[i], rb[i+1], c, 1'b0, 1'b0, d);
`ifdef SIPO_FRAME_RX_PARITY_EN
      tick(good ? ^d : ~^d, rb[5], c, 1'b0, 1'b0, d);
      tick(1'b0, rb[6], c, good, !good, d);
`else
      tick(good ? 1'b0 : 1'b1, rb[5], c, good, !good, d);
`endif
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_vld", 32'(dout_vld), 32'd0);
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_err", 32'(frame_err), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      rst = 1'b1;

`ifndef SIPO_FRAME_RX_PARITY_EN
      // good frame 4'hD, consumer always ready
      add(1,1,0, 0,4'h0,0,0); add(1,1,0, 0,4'h0,0,0); add(0,1,0, 0,4'h0,0,0);
      add(1,1,0, 0,4'h0,0,0); add(1,1,0, 0,4'h0,0,0); add(0,1,0, 1,4'hD,0,0);
      add(0,1,0, 0,4'h0,0,0);
      // bad stop bit, then an immediate start bit carrying 4'hA
      add(1,1,0, 0,4'h0,0,0); add(0,1,0, 0,4'h0,0,0); add(0,1,0, 0,4'h0,0,0);
      add(0,1,0, 0,4'h0,0,0); add(1,1,0, 0,4'h0,0,0); add(1,1,0, 0,4'h0,1,0);
      add(1,1,0, 0,4'h0,0,0); add(0,1,0, 0,4'h0,0,0); add(1,1,0, 0,4'h0,0,0);
      add(0,1,0, 0,4'h0,0,0); add(1,1,0, 0,4'h0,0,0); add(0,1,0, 1,4'hA,0,0);
      add(0,1,0, 0,4'h0,0,0);
      // three back-to-back frames 1,2,3 into a stalled consumer
      add(1,0,0, 0,4'h0,0,0); add(1,0,0, 0,4'h0,0,0); add(0,0,0, 0,4'h0,0,0);
      add(0,0,0, 0,4'h0,0,0); add(0,0,0, 0,4'h0,0,0); add(0,0,0, 1,4'h1,0,0);
      add(1,0,0, 1,4'h1,0,0); add(0,0,0, 1,4'h1,0,0); add(1,0,0, 1,4'h1,0,0);
      add(0,0,0, 1,4'h1,0,0); add(0,0,0, 1,4'h1,0,0); add(0,0,0, 1,4'h1,0,0);
      add(1,0,0, 1,4'h1,0,0); add(1,0,0, 1,4'h1,0,0); add(1,0,0, 1,4'h1,0,0);
      add(0,0,0, 1,4'h1,0,0); add(0,0,0, 1,4'h1,0,0); add(0,0,0, 1,4'h1,0,1);
      add(0,1,0, 1,4'h2,0,1); add(0,1,0, 0,4'h0,0,1); add(0,0,1, 0,4'h0,0,0);
      add(0,0,0, 0,4'h0,0,0);
      for (int i = 0; i < tbl.size(); i++) begin
         sin      = tbl[i].sin;
         dout_rdy = tbl[i].rdy;
         ovf_clr  = tbl[i].clr;
         @(posedge clk);
         #1;
         chk($sformatf("tbl%0d_vld", i), 32'(dout_vld), 32'(tbl[i].vld));
         if (tbl[i].vld) chk($sformatf("tbl%0d_dout", i), 32'(dout), 32'(tbl[i].dout));
         chk($sformatf("tbl%0d_err", i), 32'(frame_err), 32'(tbl[i].err));
         chk($sformatf("tbl%0d_ovf", i), 32'(ovf), 32'(tbl[i].ovf));
      end
`else
      // parity enabled: correct parity gives 4'hD, wrong parity drops the word
      frame(4'hD, 7'h00, 1'b0, 1'b1);
      chk("par_good_vld", 32'(dout_vld), 32'd1);
      chk("par_good_dout", 32'(dout), 32'hD);
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
      frame(4'hD, 7'h7f, 1'b0, 1'b0);
      chk("par_bad_err", 32'(frame_err), 32'd1);
      chk("par_bad_vld", 32'(dout_vld), 32'd0);
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
`endif

      // full queue, push and pop on the same edge: no overflow, order kept
      frame(4'h4, 7'h00, 1'b0, 1'b1);
      frame(4'h5, 7'h00, 1'b0, 1'b1);
`ifdef SIPO_FRAME_RX_PARITY_EN
      frame(4'h6, 7'h40, 1'b0, 1'b1);
`else
      frame(4'h6, 7'h20, 1'b0, 1'b1);
`endif
      chk("pp_full_ovf", 32'(ovf), 32'd0);
      chk("pp_full_head", 32'(dout), 32'h5);
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
      chk("pp_full_next", 32'(dout), 32'h6);
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);

      // overflow and clear in the same cycle: overflow wins
      frame(4'h7, 7'h00, 1'b0, 1'b1);
      frame(4'h8, 7'h00, 1'b0, 1'b1);
      frame(4'h9, 7'h00, 1'b1, 1'b1);
      chk("set_wins_ovf", 32'(ovf), 32'd1);
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
      chk("clr_ovf", 32'(ovf), 32'd0);

      // random traffic against the queue scoreboard
      for (int n = 0; n < 200; n++) begin
         logic [3:0] d;
         logic [6:0] rb;
         logic       good;
         d    = 4'($urandom_range(0, 15));
         rb   = 7'($urandom) | 7'($urandom);
         good = ($urandom_range(0, 15) != 0);
         frame(d, rb, 1'b0, good);
         repeat ($urandom_range(0, 2)) tick(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0, 4'h0);
      end
      repeat (3) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
      tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);

      // reset mid-frame with a word queued
      frame(4'hC, 7'h00, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      rst = 1'b0;
      #2;
      chk("mid_rst_vld", 32'(dout_vld), 32'd0);
      chk("mid_rst_dout", 32'(dout), 32'd0);
      chk("mid_rst_err", 32'(frame_err), 32'd0);
      chk("mid_rst_ovf", 32'(ovf), 32'd0);
      mq.delete();
      movf = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (8) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
